// File: rtl/soc_system_onchip_ram_pipelined.sv
// soc_system_onchip_ram_pipelined: Avalon-MM on-chip RAM with pipelined reads and post-reset clear; ONCHIP_RAM_PARITY_EN adds per-lane parity
module soc_system_onchip_ram_pipelined #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    parity_inject,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    readerror,
    output logic                    waitrequest,
    output logic                    init_done
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef enum logic {CLEAR, READY} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clr, acc, rd_acc, we, rd_perr, s_valid, s_err;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [NB-1:0]         wbe;
    logic [DATA_WIDTH-1:0] wdata, rd_word, s_data;
    always_comb begin
        clr     = state == CLEAR;
        acc     = state == READY && clken && chipselect;
        rd_acc  = acc && read && !write;
        we      = !reset && clken && (clr || (acc && write));
        waddr   = clr ? cnt : address;
        wbe     = clr ? '1 : byteenable;
        wdata   = clr ? '0 : writedata;
        rd_word = mem[address];
    end
    assign waitrequest = clr || !clken;
    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < NB; i++)
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] wpar, rpar;
    always_comb begin
        wpar = '0;
        rpar = '0;
        for (int i = 0; i < NB; i++) begin
            wpar[i] = ^wdata[8*i +: 8] ^ (parity_inject && !clr);
            rpar[i] = ^rd_word[8*i +: 8];
        end
    end
    assign rd_perr = |(rpar ^ par[address]);
    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < NB; i++)
                if (wbe[i]) par[waddr][i] <= wpar[i];
`else
    logic unused_parity;
    assign unused_parity = parity_inject;
    assign rd_perr       = 1'b0;
`endif
    always_ff @(posedge clk)
        if (reset) begin
            state         <= INIT_CLEAR != 0 ? CLEAR : READY;
            init_done     <= INIT_CLEAR == 0;
            cnt           <= '0;
            s_valid       <= 1'b0;
            s_err         <= 1'b0;
            s_data        <= '0;
            readdatavalid <= 1'b0;
            readerror     <= 1'b0;
            readdata      <= '0;
        end else if (clken) begin
            if (clr) begin
                cnt <= cnt + 1'b1;
                if (&cnt) begin
                    state     <= READY;
                    init_done <= 1'b1;
                end
            end
            s_valid       <= rd_acc;
            s_err         <= rd_acc && rd_perr;
            s_data        <= rd_word;
            readdatavalid <= READ_LATENCY == 2 ? s_valid : rd_acc;
            readerror     <= READ_LATENCY == 2 ? s_err : rd_acc && rd_perr;
            readdata      <= READ_LATENCY == 2 ? s_data : rd_word;
        end
endmodule

// File: tb/tb_soc_system_onchip_ram_pipelined.sv
// tb_soc_system_onchip_ram_pipelined: two RAM instances (latency 1 with clear, latency 2 retaining) on shared stimulus vs a transaction-level model
module tb_soc_system_onchip_ram_pipelined;
`ifdef ONCHIP_RAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1, clken = 1'b1, chipselect = 1'b0, read = 1'b0, write = 1'b0, parity_inject = 1'b0;
    logic [3:0]  address = '0, byteenable = '0;
    logic [31:0] writedata = '0;
    logic [31:0] a_rd, b_rd;
    logic        a_rdv, a_err, a_wait, a_done, b_rdv, b_err, b_wait, b_done;
    int          total = 0, bad = 0, cyc = 0;
    logic [31:0] mm [2][16];
    logic [3:0]  pm [2][16];
    int          clr_left [2];
    bit          pv [2][4];
    logic [31:0] pd [2][4];
    bit          pe [2][4];
    int          pc [2][4];
    logic [31:0] e_rd [2];
    bit          e_rdv [2], e_err [2];
    logic [31:0] fill5;

    always #5 clk = ~clk;

    soc_system_onchip_ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .INIT_CLEAR(1)) u_a (
        .clk(clk), .reset(reset), .clken(clken), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
        .parity_inject(parity_inject), .readdata(a_rd), .readdatavalid(a_rdv), .readerror(a_err),
        .waitrequest(a_wait), .init_done(a_done));

    soc_system_onchip_ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .INIT_CLEAR(0)) u_b (
        .clk(clk), .reset(reset), .clken(clken), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
        .parity_inject(parity_inject), .readdata(b_rd), .readdatavalid(b_rdv), .readerror(b_err),
        .waitrequest(b_wait), .init_done(b_done));

    // each accepted read becomes a ticket due after its latency in enabled cycles
    task automatic model_edge();
        int s;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int j = 0; j < 4; j++) pv[k][j] = 1'b0;
                e_rd[k] = '0; e_rdv[k] = 1'b0; e_err[k] = 1'b0;
                clr_left[k] = (k == 0) ? 16 : 0;
            end else if (clken) begin
                if (clr_left[k] > 0) begin
                    mm[k][16 - clr_left[k]] = '0;
                    pm[k][16 - clr_left[k]] = '0;
                    clr_left[k]--;
                end else if (chipselect && write) begin
                    for (int b = 0; b < 4; b++)
                        if (byteenable[b]) begin
                            mm[k][address][8*b +: 8] = writedata[8*b +: 8];
                            pm[k][address][b] = parity_inject & PAR;
                        end
                end else if (chipselect && read) begin
                    s = 0;
                    while (pv[k][s]) s++;
                    pv[k][s] = 1'b1; pd[k][s] = mm[k][address]; pe[k][s] = |pm[k][address]; pc[k][s] = k + 1;
                end
                e_rdv[k] = 1'b0; e_err[k] = 1'b0;
                for (int j = 0; j < 4; j++)
                    if (pv[k][j]) begin
                        pc[k][j]--;
                        if (pc[k][j] == 0) begin
                            pv[k][j] = 1'b0; e_rdv[k] = 1'b1; e_rd[k] = pd[k][j]; e_err[k] = pe[k][j];
                        end
                    end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [35:0] obs_v(int k);
        logic v;
        v = k == 0 ? a_rdv : b_rdv;
        return k == 0 ? {a_rdv, v ? a_rd : 32'h0, a_err, a_wait, a_done}
                      : {b_rdv, v ? b_rd : 32'h0, b_err, b_wait, b_done};
    endfunction

    function automatic logic [35:0] exp_v(int k);
        return {e_rdv[k], e_rdv[k] ? e_rd[k] : 32'h0, e_err[k], (clr_left[k] > 0) || !clken, clr_left[k] == 0};
    endfunction

    task automatic idle();
        reset = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0; parity_inject = 1'b0;
    endtask

    task automatic set_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be, input logic inj);
        idle();
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be; parity_inject = inj;
    endtask

    task automatic set_rd(input logic [3:0] a);
        idle();
        chipselect = 1'b1; read = 1'b1; address = a;
    endtask

    task automatic test_reset();
        int n;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (a_wait !== 1'b1 || a_done !== 1'b0 || a_rdv !== 1'b0 || a_rd !== 32'h0 || a_err !== 1'b0) begin
            bad++; $display("FAIL reset_a got w=%b d=%b v=%b rd=%h want w=1 d=0 v=0 rd=0", a_wait, a_done, a_rdv, a_rd);
        end
        total++;
        if (b_wait !== 1'b0 || b_done !== 1'b1 || b_rdv !== 1'b0 || b_rd !== 32'h0 || b_err !== 1'b0) begin
            bad++; $display("FAIL reset_b got w=%b d=%b v=%b rd=%h want w=0 d=1 v=0 rd=0", b_wait, b_done, b_rdv, b_rd);
        end
        n = 0;
        while (a_wait === 1'b1 && n < 100) begin
            tick();
            n++;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v(k) !== exp_v(k)) begin bad++; $display("FAIL clear dut%0d cyc%0d got=%h want=%h", k, cyc, obs_v(k), exp_v(k)); end
            end
        end
        total++;
        if (n != 16) begin bad++; $display("FAIL clear_len got %0d want 16", n); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            set_wr(4'(i), i == 5 ? fill5 : $urandom, 4'hF, 1'b0);
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v(k) !== exp_v(k)) begin bad++; $display("FAIL fill dut%0d cyc%0d got=%h want=%h", k, cyc, obs_v(k), exp_v(k)); end
            end
        end
        idle();
    endtask

    task automatic test_reset_midread();
        int n;
        set_rd(4'd5);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (a_rdv !== 1'b0 || b_rdv !== 1'b0) begin bad++; $display("FAIL reset_inflight got a=%b b=%b want 0 0", a_rdv, b_rdv); end
        n = 0;
        while (a_wait === 1'b1 && n < 100) begin tick(); n++; end
        total++;
        if (n != 16) begin bad++; $display("FAIL reclear_len got %0d want 16", n); end
        for (int i = 0; i < 19; i++) begin
            if (i < 16) set_rd(4'(i)); else idle();
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v(k) !== exp_v(k)) begin bad++; $display("FAIL b2b dut%0d cyc%0d got=%h want=%h", k, cyc, obs_v(k), exp_v(k)); end
            end
            if (i == 5) begin
                total++;
                if (a_rdv !== 1'b1 || a_rd !== 32'h0) begin bad++; $display("FAIL cleared_a5 got v=%b %h want 1 0", a_rdv, a_rd); end
            end
            if (i == 6) begin
                total++;
                if (b_rdv !== 1'b1 || b_rd !== fill5) begin bad++; $display("FAIL retained_b5 got v=%b %h want 1 %h", b_rdv, b_rd, fill5); end
            end
        end
    endtask

    task automatic test_bytes();
        set_wr(4'd3, 32'hDEADBEEF, 4'hF, 1'b0); tick();
        set_wr(4'd3, 32'h000000AA, 4'h1, 1'b0); tick();
        set_rd(4'd3); tick();
        total++;
        if (a_rdv !== 1'b1 || a_rd !== 32'hDEADBEAA || b_rdv !== 1'b0) begin
            bad++; $display("FAIL bytes_lat1 got av=%b ard=%h bv=%b want 1 deadbeaa 0", a_rdv, a_rd, b_rdv);
        end
        idle(); tick();
        total++;
        if (b_rdv !== 1'b1 || b_rd !== 32'hDEADBEAA || a_rdv !== 1'b0) begin
            bad++; $display("FAIL bytes_lat2 got bv=%b brd=%h av=%b want 1 deadbeaa 0", b_rdv, b_rd, a_rdv);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_v(k) !== exp_v(k)) begin bad++; $display("FAIL bytes dut%0d cyc%0d got=%h want=%h", k, cyc, obs_v(k), exp_v(k)); end
        end
    endtask

    task automatic test_clken();
        set_rd(4'd3); tick();
        set_rd(4'd0);
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (a_wait !== 1'b1 || b_wait !== 1'b1 || a_rdv !== 1'b1 || b_rdv !== 1'b0) begin
                bad++; $display("FAIL freeze got aw=%b bw=%b av=%b bv=%b want 1 1 1 0", a_wait, b_wait, a_rdv, b_rdv);
            end
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) begin
                total++;
                if (b_rdv !== 1'b1 || b_rd !== 32'hDEADBEAA) begin bad++; $display("FAIL resume_b got v=%b %h want 1 deadbeaa", b_rdv, b_rd); end
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v(k) !== exp_v(k)) begin bad++; $display("FAIL clken dut%0d cyc%0d got=%h want=%h", k, cyc, obs_v(k), exp_v(k)); end
            end
        end
    endtask

    task automatic test_rw();
        logic [31:0] d;
        d = $urandom;
        set_wr(4'd9, 32'h0BADF00D, 4'hF, 1'b0);
        read = 1'b1;
        tick();
        total++;
        if (a_rdv !== 1'b0) begin bad++; $display("FAIL rw_drop got v=%b want 0", a_rdv); end
        set_wr(4'd10, d, 4'hF, 1'b0); tick();
        set_rd(4'd10); tick();
        total++;
        if (a_rdv !== 1'b1 || a_rd !== d) begin bad++; $display("FAIL raw got v=%b %h want 1 %h", a_rdv, a_rd, d); end
        set_rd(4'd9); tick();
        total++;
        if (a_rd !== 32'h0BADF00D || b_rdv !== 1'b1 || b_rd !== d) begin
            bad++; $display("FAIL rw_store got a=%h b=%h want 0badf00d %h", a_rd, b_rd, d);
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v(k) !== exp_v(k)) begin bad++; $display("FAIL rw dut%0d cyc%0d got=%h want=%h", k, cyc, obs_v(k), exp_v(k)); end
            end
        end
    endtask

    task automatic test_parity();
        set_wr(4'd7, 32'h11223344, 4'h2, 1'b1); tick();
        set_rd(4'd7); tick();
        total++;
        if (a_rdv !== 1'b1 || a_err !== 1'b1) begin bad++; $display("FAIL par_inject got v=%b e=%b want 1 1", a_rdv, a_err); end
        idle(); tick();
        total++;
        if (b_rdv !== 1'b1 || b_err !== 1'b1 || a_err !== 1'b0) begin bad++; $display("FAIL par_inject_b got bv=%b be=%b ae=%b want 1 1 0", b_rdv, b_err, a_err); end
        set_wr(4'd7, 32'h11223344, 4'h2, 1'b0); tick();
        set_rd(4'd7); tick();
        total++;
        if (a_rdv !== 1'b1 || a_err !== 1'b0) begin bad++; $display("FAIL par_clean got v=%b e=%b want 1 0", a_rdv, a_err); end
        idle(); tick();
        total++;
        if (b_rdv !== 1'b1 || b_err !== 1'b0) begin bad++; $display("FAIL par_clean_b got v=%b e=%b want 1 0", b_rdv, b_err); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle();
            reset         = ($urandom % 64) == 0;
            clken         = ($urandom % 8) != 0;
            chipselect    = ($urandom % 4) != 0;
            read          = $urandom % 2;
            write         = ($urandom % 3) == 0;
            address       = 4'($urandom);
            byteenable    = 4'($urandom);
            writedata     = $urandom;
            parity_inject = ($urandom % 4) == 0;
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v(k) !== exp_v(k)) begin bad++; $display("FAIL random dut%0d cyc%0d got=%h want=%h", k, cyc, obs_v(k), exp_v(k)); end
            end
        end
        idle();
    endtask

    initial begin
        fill5 = 32'h12345678;
        test_reset();
        test_fill();
        test_reset_midread();
        test_bytes();
        test_clken();
        test_rw();
        if (PAR) test_parity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
